// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and helpers for the pipeline control unit.
// Optional performance counters are enabled by defining PIPELINE_CTRL_PERF_EN.
package pipeline_ctrl_pkg;

    localparam int MAX_STAGES = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DRAINED = 2'd3
    } pipeline_ctrl_state_e;

    // Width of the flush hold counter: $clog2(FLUSH_CYCLES+1)
    function automatic int unsigned flush_cnt_width(input int unsigned flush_cycles);
        return $clog2(flush_cycles + 32'd1);
    endfunction

    // Highest-set-bit thermometer: every bit at or below the top request is set
    function automatic logic [MAX_STAGES-1:0] therm_mask(input logic [MAX_STAGES-1:0] req);
        logic [MAX_STAGES-1:0] mask;
        mask[MAX_STAGES-1] = req[MAX_STAGES-1];
        for (int i = MAX_STAGES - 2; i >= 0; i--) begin
            mask[i] = mask[i+1] | req[i];
        end
        return mask;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_mask.sv
// Thermometer generator: request at index k yields a mask covering indices 0..k.
// Width is limited to pipeline_ctrl_pkg::MAX_STAGES.
module pipeline_ctrl_mask
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] mask
);

    assign mask = WIDTH'(therm_mask(MAX_STAGES'(req)));

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline stall/flush controller with drain handshake.
// Define PIPELINE_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipeline_ctrl_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 4,
    parameter int unsigned FLUSH_CYCLES   = 1,
    parameter int unsigned PERF_CNT_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_STAGES-1:0]     stage_busy_i,
    input  logic [NUM_STAGES-1:0]     stall_req_i,
    input  logic [NUM_STAGES-1:0]     flush_req_i,
    input  logic                      drain_req_i,
    output logic                      drain_ack_o,
    output logic [NUM_STAGES-1:0]     stage_stall_o,
    output logic [NUM_STAGES-1:0]     stage_flush_o,
    output logic [PERF_CNT_WIDTH-1:0] stall_cycles_o,
    output logic [PERF_CNT_WIDTH-1:0] flush_events_o
);

    localparam int unsigned     CNT_W      = flush_cnt_width(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_FLUSH   = ST_FLUSH;
    localparam logic [1:0] S_DRAIN   = ST_DRAIN;
    localparam logic [1:0] S_DRAINED = ST_DRAINED;

    logic [1:0]            state_r;
    logic [1:0]            state_n_s;
    logic [NUM_STAGES-1:0] mask_r;
    logic [NUM_STAGES-1:0] mask_n_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_n_s;
    logic                  drain_ack_r;
    logic [NUM_STAGES-1:0] stall_therm_s;
    logic [NUM_STAGES-1:0] flush_therm_s;
    logic                  flush_acc_s;
    logic                  drain_hold_s;
    logic [NUM_STAGES-1:0] stall_s;

    pipeline_ctrl_mask #(.WIDTH(NUM_STAGES)) u_stall_mask (
        .req  (stall_req_i),
        .mask (stall_therm_s)
    );

    pipeline_ctrl_mask #(.WIDTH(NUM_STAGES)) u_flush_mask (
        .req  (flush_req_i),
        .mask (flush_therm_s)
    );

    assign flush_acc_s  = |flush_req_i;
    assign drain_hold_s = (state_r == S_DRAIN) || (state_r == S_DRAINED);

    // Stage 0 is held while draining; flush always wins over stall
    assign stall_s = (stall_therm_s | NUM_STAGES'(drain_hold_s)) & ~mask_r;

    // Next-state logic: any flush request takes priority in every state
    always_comb begin
        state_n_s = state_r;
        mask_n_s  = mask_r;
        cnt_n_s   = cnt_r;
        if (flush_acc_s) begin
            state_n_s = S_FLUSH;
            mask_n_s  = mask_r | flush_therm_s;
            cnt_n_s   = FLUSH_LOAD;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (drain_req_i) begin
                        state_n_s = S_DRAIN;
                    end else begin
                        state_n_s = S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (cnt_r <= CNT_ONE) begin
                        mask_n_s  = {NUM_STAGES{1'b0}};
                        cnt_n_s   = {CNT_W{1'b0}};
                        state_n_s = drain_req_i ? S_DRAIN : S_IDLE;
                    end else begin
                        cnt_n_s = cnt_r - CNT_ONE;
                    end
                end
                S_DRAIN: begin
                    // A dropped request wins so the ack is never raised without one
                    if (!drain_req_i) begin
                        state_n_s = S_IDLE;
                    end else if (stage_busy_i == {NUM_STAGES{1'b0}}) begin
                        state_n_s = S_DRAINED;
                    end else begin
                        state_n_s = S_DRAIN;
                    end
                end
                S_DRAINED: begin
                    if (!drain_req_i) begin
                        state_n_s = S_IDLE;
                    end else begin
                        state_n_s = S_DRAINED;
                    end
                end
                default: begin
                    state_n_s = S_IDLE;
                    mask_n_s  = {NUM_STAGES{1'b0}};
                    cnt_n_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Control state, flush mask, hold counter and drain acknowledge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r     <= S_IDLE;
            mask_r      <= {NUM_STAGES{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            drain_ack_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            mask_r      <= mask_n_s;
            cnt_r       <= cnt_n_s;
            drain_ack_r <= (state_n_s == S_DRAINED);
        end
    end

    assign drain_ack_o   = drain_ack_r;
    assign stage_flush_o = mask_r;
    assign stage_stall_o = stall_s;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [PERF_CNT_WIDTH-1:0] stall_cnt_r;
    logic [PERF_CNT_WIDTH-1:0] flush_cnt_r;

    // Saturating performance counters
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_r <= {PERF_CNT_WIDTH{1'b0}};
            flush_cnt_r <= {PERF_CNT_WIDTH{1'b0}};
        end else begin
            if ((|stall_s) && !(&stall_cnt_r)) begin
                stall_cnt_r <= stall_cnt_r + PERF_CNT_WIDTH'(32'd1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (flush_acc_s && !(&flush_cnt_r)) begin
                flush_cnt_r <= flush_cnt_r + PERF_CNT_WIDTH'(32'd1);
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    assign stall_cycles_o = stall_cnt_r;
    assign flush_events_o = flush_cnt_r;
`else
    assign stall_cycles_o = {PERF_CNT_WIDTH{1'b0}};
    assign flush_events_o = {PERF_CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed self-checking bench for pipeline_ctrl_unit (counter expectations follow PIPELINE_CTRL_PERF_EN).
module tb_pipeline_ctrl_unit;

`ifdef PIPELINE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] busy;
    logic [3:0] stall_req;
    logic [3:0] flush_req;
    logic       drain_req;

    logic       a_ack;
    logic [3:0] a_stall;
    logic [3:0] a_flush;
    logic [3:0] a_scnt;
    logic [3:0] a_fcnt;

    logic       b_ack;
    logic [3:0] b_stall;
    logic [3:0] b_flush;
    logic [7:0] b_scnt;
    logic [7:0] b_fcnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_ctrl_unit #(.NUM_STAGES(4), .FLUSH_CYCLES(2), .PERF_CNT_WIDTH(4)) dut_a (
        .clk_i          (clk),
        .rst_i          (rst),
        .stage_busy_i   (busy),
        .stall_req_i    (stall_req),
        .flush_req_i    (flush_req),
        .drain_req_i    (drain_req),
        .drain_ack_o    (a_ack),
        .stage_stall_o  (a_stall),
        .stage_flush_o  (a_flush),
        .stall_cycles_o (a_scnt),
        .flush_events_o (a_fcnt)
    );

    pipeline_ctrl_unit #(.NUM_STAGES(4), .FLUSH_CYCLES(4), .PERF_CNT_WIDTH(8)) dut_b (
        .clk_i          (clk),
        .rst_i          (rst),
        .stage_busy_i   (busy),
        .stall_req_i    (stall_req),
        .flush_req_i    (flush_req),
        .drain_req_i    (drain_req),
        .drain_ack_o    (b_ack),
        .stage_stall_o  (b_stall),
        .stage_flush_o  (b_flush),
        .stall_cycles_o (b_scnt),
        .flush_events_o (b_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] pv(input logic [31:0] v);
        return PERF ? v : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; busy = 4'b0000; stall_req = 4'b0100; flush_req = 4'b0000; drain_req = 1'b0;
        tick(); tick();
        // reset state; stall still follows its request during reset
        check("rst_stall", 32'(a_stall), 32'h7);
        check("rst_flush", 32'(a_flush), 32'h0);
        check("rst_ack",   32'(a_ack),   32'h0);
        check("rst_scnt",  32'(a_scnt),  32'h0);
        check("rst_fcnt",  32'(a_fcnt),  32'h0);
        stall_req = 4'b0000; rst = 1'b0;
        tick();

        // combinational stall thermometer
        stall_req = 4'b0100; #1;
        check("stall_0100", 32'(a_stall), 32'h7);
        stall_req = 4'b1001; #1;
        check("stall_1001", 32'(a_stall), 32'hF);
        tick();
        stall_req = 4'b0000; #1;
        check("stall_none", 32'(a_stall), 32'h0);
        check("scnt_1", 32'(a_scnt), pv(32'd1));

        // single flush, two-cycle hold
        flush_req = 4'b0010; #1;
        check("flush_lat0", 32'(a_flush), 32'h0);
        tick();
        flush_req = 4'b0000;
        check("flush_c1", 32'(a_flush), 32'h3);
        tick();
        check("flush_c2", 32'(a_flush), 32'h3);
        tick();
        check("flush_end", 32'(a_flush), 32'h0);
        check("fcnt_1", 32'(a_fcnt), pv(32'd1));
        check("scnt_1b", 32'(a_scnt), pv(32'd1));

        // extended flush; flush dominates stall
        flush_req = 4'b0001;
        tick();
        flush_req = 4'b0100; stall_req = 4'b0100; #1;
        check("fx_first", 32'(a_flush), 32'h1);
        check("fx_stall0", 32'(a_stall), 32'h6);
        tick();
        flush_req = 4'b0000; #1;
        check("fx_c1", 32'(a_flush), 32'h7);
        check("fx_stall1", 32'(a_stall), 32'h0);
        tick();
        check("fx_c2", 32'(a_flush), 32'h7);
        check("fx_stall2", 32'(a_stall), 32'h0);
        tick();
        check("fx_end", 32'(a_flush), 32'h0);
        check("fx_stall3", 32'(a_stall), 32'h7);
        check("fcnt_3", 32'(a_fcnt), pv(32'd3));
        check("scnt_2", 32'(a_scnt), pv(32'd2));
        stall_req = 4'b0000;

        // drain handshake
        busy = 4'b1010; drain_req = 1'b1; #1;
        check("dr_idle_stall", 32'(a_stall), 32'h0);
        tick();
        check("dr_stall1", 32'(a_stall), 32'h1);
        check("dr_ack1", 32'(a_ack), 32'h0);
        tick();
        check("dr_stall2", 32'(a_stall), 32'h1);
        tick();
        busy = 4'b0000; #1;
        check("dr_ack_pre", 32'(a_ack), 32'h0);
        check("dr_stall3", 32'(a_stall), 32'h1);
        tick();
        check("dr_ack_rise", 32'(a_ack), 32'h1);
        check("dr_stall4", 32'(a_stall), 32'h1);
        tick();
        check("dr_ack_hold", 32'(a_ack), 32'h1);
        drain_req = 1'b0; #1;
        check("dr_ack_same", 32'(a_ack), 32'h1);
        tick();
        check("dr_ack_fall", 32'(a_ack), 32'h0);
        check("dr_release", 32'(a_stall), 32'h0);
        check("scnt_7", 32'(a_scnt), pv(32'd7));

        // flush out of DRAINED, then back to DRAIN
        drain_req = 1'b1;
        tick(); tick();
        check("ab_ack", 32'(a_ack), 32'h1);
        flush_req = 4'b1000;
        tick();
        flush_req = 4'b0000; #1;
        check("ab_ack_drop", 32'(a_ack), 32'h0);
        check("ab_flush1", 32'(a_flush), 32'hF);
        check("ab_stall1", 32'(a_stall), 32'h0);
        tick();
        check("ab_flush2", 32'(a_flush), 32'hF);
        tick();
        check("ab_flush_end", 32'(a_flush), 32'h0);
        check("ab_redrain", 32'(a_stall), 32'h1);
        check("ab_ack2", 32'(a_ack), 32'h0);
        drain_req = 1'b0;
        tick();
        check("ab_idle", 32'(a_stall), 32'h0);
        check("scnt_10", 32'(a_scnt), pv(32'd10));
        check("fcnt_4", 32'(a_fcnt), pv(32'd4));

        // reset in the middle of a four-cycle flush
        rst = 1'b1; #1; rst = 1'b0;
        tick();
        flush_req = 4'b0001;
        tick();
        flush_req = 4'b0000;
        tick();
        check("rmf_active", 32'(b_flush), 32'h1);
        rst = 1'b1; #1;
        check("rmf_abort_b", 32'(b_flush), 32'h0);
        check("rmf_abort_a", 32'(a_flush), 32'h0);
        check("rmf_scnt", 32'(b_scnt), 32'h0);
        check("rmf_fcnt", 32'(b_fcnt), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check("rmf_idle", 32'(b_flush), 32'h0);
        check("rmf_ack", 32'(b_ack), 32'h0);

        // saturation of the narrow counters
        stall_req = 4'b0001; #1;
        check("stall_0001", 32'(a_stall), 32'h1);
        for (int i = 0; i < 20; i++) tick();
        stall_req = 4'b0000;
        check("sat_scnt_a", 32'(a_scnt), pv(32'd15));
        check("sat_scnt_b", 32'(b_scnt), pv(32'd20));
        flush_req = 4'b0001;
        for (int i = 0; i < 20; i++) tick();
        flush_req = 4'b0000;
        check("sat_fcnt_a", 32'(a_fcnt), pv(32'd15));
        check("sat_fcnt_b", 32'(b_fcnt), pv(32'd20));
        check("sat_scnt_hold", 32'(a_scnt), pv(32'd15));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl_unit.md
# pipeline_ctrl_unit

Central control unit that drives the stall/flush control ports of a chain of `NUM_STAGES` pipeline registers and consumes their busy status. It turns per-stage hazard (stall) and squash (flush) requests into per-stage control masks. It also provides a drain handshake that empties the pipe before mode or table switches. It is the controlling end of the pipeline register ctrl/status interface.

## Interface
- `NUM_STAGES`, default 4: number of controlled stages. Index 0 is the entry (youngest) stage.
- `FLUSH_CYCLES`, default 1: cycles a flush mask is held; must be ≥ 1.
- `PERF_CNT_WIDTH`, default 32: width of the performance counters.

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset; asynchronous, active-high
- `stage_busy_i`  in  NUM_STAGES  stage k holds valid data
- `stall_req_i`  in  NUM_STAGES  stage k requests a stall (hazard)
- `flush_req_i`  in  NUM_STAGES  stage k requests a flush of itself and all younger stages
- `drain_req_i`  in  1  level request to empty the pipe
- `drain_ack_o`  out  1  pipe is empty and entry is blocked
- `stage_stall_o`  out  NUM_STAGES  per-stage stall
- `stage_flush_o`  out  NUM_STAGES  per-stage flush
- `stall_cycles_o`  out  PERF_CNT_WIDTH  cycles with any stall asserted
- `flush_events_o`  out  PERF_CNT_WIDTH  accepted flush requests

## Operation
- Thermometer rule: a request at index k covers indices 0..k. Simultaneous requests are reduced to the highest requesting index. A bitwise OR of thermometers gives the same result.
- Stall path:
  - Combinational, zero latency: `stage_stall_o = therm(stall_req_i)`.
  - In DRAIN and DRAINED, bit 0 is additionally forced to 1.
  - Any bit with `stage_flush_o` high is forced to 0, because flush dominates stall.
- Flush path is registered. A cycle with `flush_req_i != 0` is an accepted flush request:
  - Flush mask register ← mask OR `therm(flush_req_i)`.
  - Counter ← `FLUSH_CYCLES`.
  - State → FLUSH.
- States:
  - IDLE: no flush, no forced stall.
    - Flush request → FLUSH.
    - `drain_req_i` → DRAIN.
  - FLUSH: `stage_flush_o` = mask. Counter decrements each cycle.
    - A new request ORs into the mask and reloads the counter.
    - When the counter reaches 0, the mask clears and the state becomes DRAIN if `drain_req_i`=1, otherwise IDLE.
  - DRAIN: stage 0 is stalled.
    - Flush request → FLUSH.
    - `stage_busy_i == 0` → DRAINED.
    - `drain_req_i`=0 → IDLE.
    - Flush has priority over all other transitions.
  - DRAINED: `drain_ack_o`=1 and stage 0 is stalled.
    - `drain_req_i`=0 → IDLE.
    - Flush request → FLUSH, and `drain_ack_o` drops the same cycle the state leaves DRAINED.
- Reset:
  - State = IDLE, flush mask = 0, counter = 0, `drain_ack_o` = 0, both perf counters = 0.
  - `stage_stall_o` follows `stall_req_i` combinationally.
  - Reset asserted mid-flush or mid-drain aborts the operation immediately.

## Timing
- `stall_req_i` → `stage_stall_o`: same cycle.
- `flush_req_i` at edge n → `stage_flush_o` high during cycles n+1 .. n+`FLUSH_CYCLES`.
- DRAIN → DRAINED: the edge after `stage_busy_i` is observed all-zero. `drain_ack_o` is registered (state decode).
- `drain_req_i` deassert → `drain_ack_o` low and stage 0 released on the next cycle.

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined:
  - `stall_cycles_o` increments every cycle in which `stage_stall_o != 0`.
  - `flush_events_o` increments on every accepted flush request.
  - Both counters saturate at all-ones and never wrap.
- Not defined: counter logic is absent, and both outputs are tied to 0.

## Structure
- Package `pipeline_ctrl_pkg` holds:
  - The `pipeline_ctrl_state_e` enum (IDLE, FLUSH, DRAIN, DRAINED).
  - A `therm_mask` function.
  - Counter width constant `$clog2(FLUSH_CYCLES+1)`.
- One sub-module, `pipeline_ctrl_mask`: parameterised highest-set-bit thermometer generator, instantiated for both stall and flush.

## Test plan
- Stall, NUM_STAGES=4: `stall_req_i`=4'b0100 → `stage_stall_o`=4'b0111 in the same cycle. `stall_req_i`=4'b1001 → 4'b1111.
- Flush, FLUSH_CYCLES=2: `flush_req_i`=4'b0010 for one cycle → `stage_flush_o`=4'b0011 for exactly 2 cycles, then 0. `flush_events_o`=1.
- Flush extended: request 4'b0001, then 4'b0100 one cycle later → mask 4'b0111 held 2 cycles after the second request. `stage_stall_o` bits 0..2 are 0 during the flush even with `stall_req_i`=4'b0100.
- Drain: `drain_req_i`=1 with `stage_busy_i`=4'b1010 clearing to 0 after 3 cycles → `stage_stall_o[0]`=1 throughout. `drain_ack_o` rises one cycle after busy reads 0 and falls one cycle after `drain_req_i` drops.
- Reset mid-flush (FLUSH_CYCLES=4, reset asserted in cycle 2) → `stage_flush_o`=0 immediately and state IDLE. With PERF_EN, counters read 0 after reset. Counters preloaded near all-ones saturate.
